// File: rtl/mips_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_prog_loader_if
// Description : Byte-stream input, Mem write port and CPU control bundle
//               between a program source, the boot loader and pipe_MIPS32.
//               ADDR_W must not exceed 16.
// Revision    : 1.0  initial release
// ============================================================================
interface mips_prog_loader_if #(
  parameter int ADDR_W = 10
) ();

  // Byte stream from the program source
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              rearm;

  // Single write port into the unified Mem
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // CPU run control and status
  logic              cpu_hold;
  logic              cpu_start;
  logic              load_err;
  logic [15:0]       words_done;

  // Program source / system side
  modport master (
    output in_valid,
    output in_data,
    output rearm,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_hold,
    input  cpu_start,
    input  load_err,
    input  words_done
  );

  // Loader side
  modport slave (
    input  in_valid,
    input  in_data,
    input  rearm,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_hold,
    output cpu_start,
    output load_err,
    output words_done
  );

endinterface
`default_nettype wire

// File: rtl/mips_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : mips_prog_loader
// Description : Boot loader for pipe_MIPS32. Receives a framed program image
//               (4-byte header: start address, word count; big-endian payload
//               words; XOR checksum byte), writes each word into Mem through a
//               single write port, and keeps the CPU held until the image has
//               been verified, then releases it with a one-cycle start pulse.
// Revision    : 1.0  initial release
// ============================================================================
module mips_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              reset,
  mips_prog_loader_if.slave bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]        r_state;
  logic [1:0]        r_byte_cnt;     // byte position within header / word
  logic [15:0]       r_start;        // frame start word address
  logic [15:0]       r_count;        // frame word count N
  logic [23:0]       r_word;         // first three bytes of the word in flight
  logic [7:0]        r_csum;         // running XOR of payload bytes
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [15:0]       r_words_done;
  logic              r_cpu_hold;
  logic              r_cpu_start;
  logic              r_load_err;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        w_in_ready;
  logic        w_accept;
  logic        w_byte3;          // current accepted byte is the 4th of a group
  logic        w_hdr_done;       // last header byte accepted
  logic        w_word_done;      // last byte of a payload word accepted
  logic        w_chk_take;       // checksum byte accepted
  logic        w_rearm_take;     // rearm honoured (only in DONE/ERR)
  logic [15:0] w_count_hdr;      // word count as it completes on the 4th byte
  logic [15:0] w_next_done;
  logic        w_last_word;
  logic        w_csum_ok;
  logic [31:0] w_word;
  logic [15:0] w_addr_sum;       // full-width sum; Mem uses the low ADDR_W bits
  logic        w_unused_addr_hi;

  assign w_in_ready   = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_byte3      = (r_byte_cnt == 2'd3);
  assign w_hdr_done   = w_accept && (r_state == S_HDR)  && w_byte3;
  assign w_word_done  = w_accept && (r_state == S_DATA) && w_byte3;
  assign w_chk_take   = w_accept && (r_state == S_CHK);
  assign w_rearm_take = bus.rearm && ((r_state == S_DONE) || (r_state == S_ERR));

  assign w_count_hdr  = {r_count[15:8], bus.in_data};
  assign w_next_done  = r_words_done + 16'd1;
  assign w_last_word  = (w_next_done == r_count);
  assign w_csum_ok    = (bus.in_data == r_csum);
  assign w_word       = {r_word, bus.in_data};

  // Word index equals words_done while the frame is in progress; the sum
  // wraps naturally at 16 bits and again at the Mem width.
  assign w_addr_sum       = r_start + r_words_done;
  assign w_unused_addr_hi = ^w_addr_sum;

  // --------------------------------------------------------------------------
  // Frame sequencing: state and byte position within header / word
  // --------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state    <= S_HDR;
      r_byte_cnt <= 2'd0;
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_byte3) begin
              r_state <= (w_count_hdr == 16'd0) ? S_CHK : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_byte3 && w_last_word) begin
              r_state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (w_accept) begin
            r_state <= w_csum_ok ? S_DONE : S_ERR;
          end
        end
        S_DONE, S_ERR: begin
          if (bus.rearm) begin
            r_state    <= S_HDR;
            r_byte_cnt <= 2'd0;
          end
        end
        default: begin
          r_state    <= S_HDR;
          r_byte_cnt <= 2'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Header capture: start address then word count, both high byte first
  // --------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_start <= 16'd0;
      r_count <= 16'd0;
    end else if (w_accept && (r_state == S_HDR)) begin
      case (r_byte_cnt)
        2'd0:    r_start[15:8] <= bus.in_data;
        2'd1:    r_start[7:0]  <= bus.in_data;
        2'd2:    r_count[15:8] <= bus.in_data;
        default: r_count[7:0]  <= bus.in_data;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Payload word assembly (MSB first) and running checksum
  // --------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_word <= 24'd0;
      r_csum <= 8'd0;
    end else if (w_rearm_take) begin
      r_csum <= 8'd0;
    end else if (w_accept && (r_state == S_DATA)) begin
      r_word <= {r_word[15:0], bus.in_data};
      r_csum <= r_csum ^ bus.in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Mem write port: one-cycle strobe the cycle after a word completes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_mem_we <= w_word_done;
      if (w_word_done) begin
        r_mem_addr  <= w_addr_sum[ADDR_W-1:0];
        r_mem_wdata <= w_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Word counter: steps together with the write strobe, cleared on rearm
  // --------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_words_done <= 16'd0;
    end else if (w_rearm_take) begin
      r_words_done <= 16'd0;
    end else if (w_word_done) begin
      r_words_done <= w_next_done;
    end
  end

  // --------------------------------------------------------------------------
  // CPU control: release and start pulse on a good checksum, sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_cpu_hold  <= 1'b1;
      r_cpu_start <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_cpu_start <= 1'b0;
      if (w_rearm_take) begin
        r_cpu_hold <= 1'b1;
        r_load_err <= 1'b0;
      end else if (w_chk_take) begin
        if (w_csum_ok) begin
          r_cpu_hold  <= 1'b0;
          r_cpu_start <= 1'b1;
        end else begin
          r_load_err  <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready   = w_in_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.cpu_hold   = r_cpu_hold;
  assign bus.cpu_start  = r_cpu_start;
  assign bus.load_err   = r_load_err;
  assign bus.words_done = r_words_done;

endmodule
`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_prog_loader
// Description : Directed self-checking bench for the MIPS program loader.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mips_prog_loader;

  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk1  (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  int cyc        = 0;
  int start_cnt  = 0;
  int start_cyc  = -1;
  int accept_cyc = -1;
  int gap_max    = 0;
  logic start_hold = 1'b1;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  logic [31:0] img [0:15];
  logic [31:0] fact [0:10] = '{
    32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
    32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
    32'h3460fffc, 32'h2542fffe, 32'hfc000000
  };

  // cycle counter, updated on the active edge
  always @(posedge clk) cyc <= cyc + 1;

  // record Mem writes and start pulses mid-cycle
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (bus.cpu_start === 1'b1) begin
      start_cnt++;
      start_cyc  = cyc;
      start_hold = bus.cpu_hold;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    start_cnt  = 0;
    start_cyc  = -1;
    start_hold = 1'b1;
  endtask

  task automatic load_fact();
    for (int i = 0; i < 11; i++) img[i] = fact[i];
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    int g;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (n >= 32) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(negedge clk);
    accept_cyc   = cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    g = $urandom_range(gap_max, 0);
    repeat (g) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] start, input logic [15:0] n,
                            input logic [7:0] flip);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    send_byte(start[15:8]);
    send_byte(start[7:0]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      for (int k = 3; k >= 0; k--) begin
        b  = img[i][8*k +: 8];
        cs = cs ^ b;
        send_byte(b);
      end
    end
    send_byte(cs ^ flip);
  endtask

  task automatic do_rearm();
    bus.rearm = 1'b1;
    @(negedge clk);
    bus.rearm = 1'b0;
    @(negedge clk);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.rearm    = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
    checks++; if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_cpu_hold got=%b exp=1", bus.cpu_hold); end
    checks++; if (bus.cpu_start !== 1'b0) begin failures++; $display("FAIL reset_cpu_start got=%b exp=0", bus.cpu_start); end
    checks++; if (bus.load_err !== 1'b0) begin failures++; $display("FAIL reset_load_err got=%b exp=0", bus.load_err); end
    checks++; if (bus.words_done !== 16'd0) begin failures++; $display("FAIL reset_words_done got=%0d exp=0", bus.words_done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_factorial();
    load_fact();
    clear_log();
    gap_max = 0;
    send_frame(16'h0000, 16'd11, 8'h00);
    repeat (4) @(negedge clk);
    checks++; if (wr_addr.size() != 11) begin failures++; $display("FAIL fact_write_count got=%0d exp=11", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size() && i < 11; i++) begin
      checks++;
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== fact[i]) begin
        failures++;
        $display("FAIL fact_write[%0d] got=%h:%h exp=%h:%h", i, wr_addr[i], wr_data[i], ADDR_W'(i), fact[i]);
      end
    end
    checks++; if (start_cnt != 1) begin failures++; $display("FAIL fact_start_pulses got=%0d exp=1", start_cnt); end
    checks++; if (start_hold !== 1'b0) begin failures++; $display("FAIL fact_hold_at_start got=%b exp=0", start_hold); end
    checks++; if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL fact_cpu_hold got=%b exp=0", bus.cpu_hold); end
    checks++; if (bus.words_done !== 16'd11) begin failures++; $display("FAIL fact_words_done got=%0d exp=11", bus.words_done); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fact_done_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.load_err !== 1'b0) begin failures++; $display("FAIL fact_load_err got=%b exp=0", bus.load_err); end
  endtask

  task automatic test_bad_checksum();
    do_rearm();
    checks++; if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL rearm_cpu_hold got=%b exp=1", bus.cpu_hold); end
    checks++; if (bus.words_done !== 16'd0) begin failures++; $display("FAIL rearm_words_done got=%0d exp=0", bus.words_done); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rearm_in_ready got=%b exp=1", bus.in_ready); end
    load_fact();
    clear_log();
    send_frame(16'h0000, 16'd11, 8'h01);
    repeat (4) @(negedge clk);
    checks++; if (wr_addr.size() != 11) begin failures++; $display("FAIL badcs_write_count got=%0d exp=11", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size() && i < 11; i++) begin
      checks++;
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== fact[i]) begin
        failures++;
        $display("FAIL badcs_write[%0d] got=%h:%h exp=%h:%h", i, wr_addr[i], wr_data[i], ADDR_W'(i), fact[i]);
      end
    end
    checks++; if (bus.load_err !== 1'b1) begin failures++; $display("FAIL badcs_load_err got=%b exp=1", bus.load_err); end
    checks++; if (start_cnt != 0) begin failures++; $display("FAIL badcs_start_pulses got=%0d exp=0", start_cnt); end
    checks++; if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL badcs_cpu_hold got=%b exp=1", bus.cpu_hold); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL badcs_in_ready got=%b exp=0", bus.in_ready); end
    do_rearm();
    checks++; if (bus.load_err !== 1'b0) begin failures++; $display("FAIL badcs_rearm_load_err got=%b exp=0", bus.load_err); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL badcs_rearm_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_addr_wrap();
    img[0] = 32'hAABBCCDD;
    img[1] = 32'h11223344;
    clear_log();
    send_frame(16'h03FF, 16'd2, 8'h00);
    repeat (4) @(negedge clk);
    checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL wrap_write_count got=%0d exp=2", wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      checks++; if (wr_addr[0] !== 10'd1023 || wr_data[0] !== 32'hAABBCCDD) begin failures++; $display("FAIL wrap_write0 got=%h:%h exp=3ff:aabbccdd", wr_addr[0], wr_data[0]); end
      checks++; if (wr_addr[1] !== 10'd0 || wr_data[1] !== 32'h11223344) begin failures++; $display("FAIL wrap_write1 got=%h:%h exp=000:11223344", wr_addr[1], wr_data[1]); end
    end
    checks++; if (start_cnt != 1) begin failures++; $display("FAIL wrap_start_pulses got=%0d exp=1", start_cnt); end
    do_rearm();
  endtask

  task automatic test_empty_frame();
    clear_log();
    send_frame(16'h0000, 16'd0, 8'h00);
    repeat (4) @(negedge clk);
    checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL empty_write_count got=%0d exp=0", wr_addr.size()); end
    checks++; if (start_cnt != 1) begin failures++; $display("FAIL empty_start_pulses got=%0d exp=1", start_cnt); end
    checks++; if (start_cyc != accept_cyc) begin failures++; $display("FAIL empty_start_cycle got=%0d exp=%0d", start_cyc, accept_cyc); end
    checks++; if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL empty_cpu_hold got=%b exp=0", bus.cpu_hold); end
    do_rearm();
  endtask

  task automatic test_gapped();
    load_fact();
    clear_log();
    gap_max = 3;
    send_frame(16'h0000, 16'd11, 8'h00);
    gap_max = 0;
    repeat (4) @(negedge clk);
    checks++; if (wr_addr.size() != 11) begin failures++; $display("FAIL gap_write_count got=%0d exp=11", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size() && i < 11; i++) begin
      checks++;
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== fact[i]) begin
        failures++;
        $display("FAIL gap_write[%0d] got=%h:%h exp=%h:%h", i, wr_addr[i], wr_data[i], ADDR_W'(i), fact[i]);
      end
    end
    checks++; if (start_cnt != 1) begin failures++; $display("FAIL gap_start_pulses got=%0d exp=1", start_cnt); end
    do_rearm();
  endtask

  // rearm pulsed mid-header must not disturb the frame; checksum DE^AD^BE^EF = 22
  task automatic test_rearm_ignored();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h05);
    do_rearm();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h22);
    repeat (4) @(negedge clk);
    checks++; if (wr_addr.size() != 1) begin failures++; $display("FAIL rearm_ign_write_count got=%0d exp=1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      checks++; if (wr_addr[0] !== 10'd5 || wr_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL rearm_ign_write got=%h:%h exp=005:deadbeef", wr_addr[0], wr_data[0]); end
    end
    checks++; if (start_cnt != 1) begin failures++; $display("FAIL rearm_ign_start got=%0d exp=1", start_cnt); end
    do_rearm();
  endtask

  task automatic test_reset_mid_frame();
    load_fact();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h05);
    for (int i = 0; i < 2; i++) begin
      for (int k = 3; k >= 0; k--) send_byte(img[i][8*k +: 8]);
    end
    send_byte(img[2][31:24]);
    send_byte(img[2][23:16]);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL rstmid_write_count got=%0d exp=2", wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      checks++; if (wr_addr[1] !== 10'h21 || wr_data[1] !== fact[1]) begin failures++; $display("FAIL rstmid_write1 got=%h:%h exp=021:%h", wr_addr[1], wr_data[1], fact[1]); end
    end
    checks++; if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL rstmid_cpu_hold got=%b exp=1", bus.cpu_hold); end
    checks++; if (bus.words_done !== 16'd0) begin failures++; $display("FAIL rstmid_words_done got=%0d exp=0", bus.words_done); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
    img[0] = 32'hAABBCCDD;
    img[1] = 32'h11223344;
    clear_log();
    send_frame(16'h0100, 16'd2, 8'h00);
    repeat (4) @(negedge clk);
    checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL rstmid_fresh_count got=%0d exp=2", wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      checks++; if (wr_addr[0] !== 10'h100 || wr_data[0] !== 32'hAABBCCDD) begin failures++; $display("FAIL rstmid_fresh0 got=%h:%h exp=100:aabbccdd", wr_addr[0], wr_data[0]); end
      checks++; if (wr_addr[1] !== 10'h101 || wr_data[1] !== 32'h11223344) begin failures++; $display("FAIL rstmid_fresh1 got=%h:%h exp=101:11223344", wr_addr[1], wr_data[1]); end
    end
    checks++; if (start_cnt != 1) begin failures++; $display("FAIL rstmid_fresh_start got=%0d exp=1", start_cnt); end
    checks++; if (bus.words_done !== 16'd2) begin failures++; $display("FAIL rstmid_fresh_words got=%0d exp=2", bus.words_done); end
  endtask

  initial begin
    test_reset();
    test_factorial();
    test_bad_checksum();
    test_addr_wrap();
    test_empty_frame();
    test_gapped();
    test_rearm_ignored();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
